// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the SimpleRISC pipeline sequencing control.
// Used by hazard_stall_controller and hazard_detect.
package pipe_ctrl_pkg;

    localparam int DEFAULT_REG_ADDR_W = 5;
    localparam int ZERO_REG           = 0;

    typedef enum logic [1:0] {
        RUN,
        LU_STALL,
        MC_WAIT,
        FLUSH
    } state_t;

endpackage

// File: rtl/hazard_stall_controller_hazard_detect.sv
// Combinational load-use comparator: does the OF instruction read the register
// an EX-stage load is about to write? Register 0 never creates a hazard.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic                  uses_rs1,
    input  logic                  uses_rs2,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  is_load,
    output logic                  hit
);

    logic rd_nonzero;
    logic match_rs1;
    logic match_rs2;

    assign rd_nonzero = (rd != REG_ADDR_W'(ZERO_REG));
    assign match_rs1  = uses_rs1 && (rs1 == rd);
    assign match_rs2  = uses_rs2 && (rs2 == rd);
    assign hit        = is_load && rd_nonzero && (match_rs1 || match_rs2);

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline stall/bubble/flush sequencer for load-use, multi-cycle EX and taken branches.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W      = DEFAULT_REG_ADDR_W,
    parameter int LOAD_USE_CYCLES = 1,
    parameter int MC_TIMEOUT      = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] rs1_OF,
    input  logic [REG_ADDR_W-1:0] rs2_OF,
    input  logic                  uses_rs1_OF,
    input  logic                  uses_rs2_OF,
    input  logic [REG_ADDR_W-1:0] rd_EX,
    input  logic                  is_load_EX,
    input  logic                  mc_start,
    input  logic                  mc_done,
    input  logic                  branch_taken_EX,
    output logic                  stall_IF,
    output logic                  stall_OF,
    output logic                  stall_EX,
    output logic                  bubble_EX,
    output logic                  bubble_MA,
    output logic                  flush_IF,
    output logic                  flush_OF,
    output logic                  busy,
    output logic                  mc_timeout,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_flush_cnt
);

    localparam logic [3:0] LU_RELOAD = 4'(LOAD_USE_CYCLES - 1);
    localparam logic [7:0] WAIT_LAST = 8'(MC_TIMEOUT - 1);

    state_t     state_reg, state_next;
    logic [3:0] lu_cnt_reg, lu_cnt_next;
    logic [7:0] wait_cnt_reg, wait_cnt_next;
    logic       pending_flush_reg, pending_flush_next;
    logic       timeout_reg;
    logic       timeout_now;
    logic       lu_hit;
    logic       hold_front, hold_ex, bub_ex, flush_front;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .rs1      (rs1_OF),
        .rs2      (rs2_OF),
        .uses_rs1 (uses_rs1_OF),
        .uses_rs2 (uses_rs2_OF),
        .rd       (rd_EX),
        .is_load  (is_load_EX),
        .hit      (lu_hit)
    );

    always_comb begin
        state_next         = state_reg;
        lu_cnt_next        = lu_cnt_reg;
        wait_cnt_next      = wait_cnt_reg;
        pending_flush_next = pending_flush_reg;
        timeout_now        = 1'b0;
        hold_front         = 1'b0;
        hold_ex            = 1'b0;
        bub_ex             = 1'b0;
        flush_front        = 1'b0;
        case (state_reg)
            RUN: begin
                if (mc_start) begin
                    hold_front         = 1'b1;
                    hold_ex            = 1'b1;
                    pending_flush_next = branch_taken_EX;
                    wait_cnt_next      = 8'd0;
                    state_next         = MC_WAIT;
                end else if (branch_taken_EX) begin
                    flush_front = 1'b1;
                end else if (lu_hit) begin
                    hold_front = 1'b1;
                    bub_ex     = 1'b1;
                    if (LOAD_USE_CYCLES > 1) begin
                        lu_cnt_next = LU_RELOAD;
                        state_next  = LU_STALL;
                    end
                end
            end
            LU_STALL: begin
                hold_front  = 1'b1;
                bub_ex      = 1'b1;
                lu_cnt_next = lu_cnt_reg - 4'd1;
                if (lu_cnt_reg == 4'd1) begin
                    state_next = RUN;
                end
            end
            MC_WAIT: begin
                // Completion takes priority over the timeout on the same cycle.
                if (mc_done) begin
                    state_next = pending_flush_reg ? FLUSH : RUN;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    timeout_now = 1'b1;
                    state_next  = pending_flush_reg ? FLUSH : RUN;
                end else begin
                    hold_front    = 1'b1;
                    hold_ex       = 1'b1;
                    wait_cnt_next = wait_cnt_reg + 8'd1;
                end
            end
            FLUSH: begin
                flush_front        = 1'b1;
                pending_flush_next = 1'b0;
                state_next         = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= RUN;
            lu_cnt_reg        <= 4'd0;
            wait_cnt_reg      <= 8'd0;
            pending_flush_reg <= 1'b0;
            timeout_reg       <= 1'b0;
        end else begin
            state_reg         <= state_next;
            lu_cnt_reg        <= lu_cnt_next;
            wait_cnt_reg      <= wait_cnt_next;
            pending_flush_reg <= pending_flush_next;
            timeout_reg       <= timeout_reg | timeout_now;
        end
    end

    // Gating with rst_n keeps every output low while reset is held, even with live inputs.
    assign stall_IF   = rst_n & hold_front;
    assign stall_OF   = rst_n & hold_front;
    assign stall_EX   = rst_n & hold_ex;
    assign bubble_MA  = rst_n & hold_ex;
    assign bubble_EX  = rst_n & bub_ex;
    assign flush_IF   = rst_n & flush_front;
    assign flush_OF   = rst_n & flush_front;
    assign busy       = rst_n & (state_reg != RUN);
    assign mc_timeout = rst_n & (timeout_reg | timeout_now);

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_reg;
    logic [31:0] perf_flush_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_reg <= 32'd0;
            perf_flush_reg <= 32'd0;
        end else begin
            if (stall_IF && (perf_stall_reg != 32'hFFFF_FFFF)) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
            if (flush_IF && (perf_flush_reg != 32'hFFFF_FFFF)) begin
                perf_flush_reg <= perf_flush_reg + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = perf_stall_reg;
    assign perf_flush_cnt = perf_flush_reg;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the 5-stage SimpleRISC pipeline (IF, OF, EX, MA, RW), working alongside the EX-stage operand forwarding mux.
- Forwarding resolves EX-input hazards from MA/RW results; this block handles the cases forwarding cannot:
  - load-use hazards
  - multi-cycle EX operations (mul/div)
  - taken-branch flushes
- Drives per-stage stall, bubble and flush controls via a small FSM with counters.

Parameters:
REG_ADDR_W, 5, register-specifier width; register 0 is the hardwired zero register and never causes a hazard
LOAD_USE_CYCLES, 1, stall cycles inserted per load-use hazard (1..15; >1 models slow data memory)
MC_TIMEOUT, 64, max cycles to wait for mc_done before abort (2..255)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
rs1_OF  in  REG_ADDR_W  source reg 1 of instruction in OF
rs2_OF  in  REG_ADDR_W  source reg 2 of instruction in OF
uses_rs1_OF  in  1  OF instruction reads rs1
uses_rs2_OF  in  1  OF instruction reads rs2
rd_EX  in  REG_ADDR_W  destination of instruction in EX
is_load_EX  in  1  EX instruction is a load
mc_start  in  1  EX instruction is multi-cycle; valid one cycle
mc_done  in  1  multi-cycle unit result ready
branch_taken_EX  in  1  EX instruction resolved as taken branch
stall_IF  out  1  hold PC/IF register
stall_OF  out  1  hold OF/EX pipeline register
stall_EX  out  1  hold EX instruction in place
bubble_EX  out  1  insert NOP into EX next cycle
bubble_MA  out  1  insert NOP into MA next cycle
flush_IF  out  1  squash IF instruction
flush_OF  out  1  squash OF instruction
busy  out  1  FSM not in RUN
mc_timeout  out  1  sticky: multi-cycle op aborted on timeout
perf_stall_cnt  out  32  stall cycles (optional feature)
perf_flush_cnt  out  32  flush events (optional feature)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=RUN; all counters, pending_flush and mc_timeout cleared.
  - All outputs 0 while reset is held.
  - Reset mid-stall or mid-MC_WAIT aborts immediately; no residual flush.
- Hazard term: lu_hit = is_load_EX & rd_EX!=0 & ((uses_rs1_OF & rs1_OF==rd_EX) | (uses_rs2_OF & rs2_OF==rd_EX)).
- Outputs are combinational from state and inputs: zero latency in the detection cycle.
- States:
  - RUN: priority mc_start > branch_taken_EX > lu_hit.
    - mc_start: stall_IF=stall_OF=stall_EX=bubble_MA=1; if branch_taken_EX is also set, latch pending_flush; load wait_cnt=0; go MC_WAIT.
    - branch_taken_EX only: flush_IF=flush_OF=1 for one cycle; stay RUN; lu_hit ignored (the OF instruction is squashed).
    - lu_hit only: stall_IF=stall_OF=bubble_EX=1. If LOAD_USE_CYCLES>1, load lu_cnt=LOAD_USE_CYCLES-1 and go LU_STALL; else stay RUN.
  - LU_STALL:
    - stall_IF=stall_OF=bubble_EX=1; lu_hit not re-evaluated; lu_cnt decrements.
    - At lu_cnt==1 the next state is RUN; the last stall cycle is the one where lu_cnt==1.
  - MC_WAIT:
    - stall_IF=stall_OF=stall_EX=bubble_MA=1; wait_cnt increments; all other inputs ignored.
    - mc_done: deassert stalls that cycle; if pending_flush, go FLUSH, else RUN.
    - wait_cnt==MC_TIMEOUT-1 without mc_done: set mc_timeout (sticky until reset), deassert stalls, go FLUSH if pending_flush, else RUN.
    - mc_done on the same cycle as the timeout: completion wins; no timeout flag.
  - FLUSH: flush_IF=flush_OF=1 for exactly one cycle; clear pending_flush; go RUN.
- busy=1 in LU_STALL, MC_WAIT, FLUSH.
- Invariants:
  - flush_X and stall_X are never both 1.
  - bubble_EX and bubble_MA are never both 1.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - perf_stall_cnt increments every cycle stall_IF=1.
  - perf_flush_cnt increments every cycle flush_IF=1.
  - Both 32-bit, saturating at 0xFFFFFFFF, cleared by reset.
- Undefined: both ports tied to 0; no counter flops.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state enum {RUN, LU_STALL, MC_WAIT, FLUSH}
  - REG_ADDR_W default
  - ZERO_REG=0
- One natural sub-module: hazard_detect, the combinational lu_hit comparator, also reusable for a future branch-operand hazard check.

Test Plan:
- Load-use: EX load with rd_EX=5, OF rs1_OF=5, uses_rs1_OF=1 -> stall_IF=stall_OF=bubble_EX=1 for exactly 1 cycle (LOAD_USE_CYCLES=1); rd_EX=0 gives no stall.
- Slow load, LOAD_USE_CYCLES=3, rs2_OF=rd_EX=7 -> stalls for 3 consecutive cycles, busy=1 for the final 2, then RUN.
- Multi-cycle: mc_start pulse, mc_done 10 cycles later -> stall_EX=bubble_MA=1 for 10 cycles, 0 on the done cycle.
- mc_start and branch_taken_EX together, mc_done after 4 cycles -> 4 stall cycles, then exactly one flush_IF=flush_OF=1 cycle.
- Timeout, MC_TIMEOUT=8, no mc_done -> stalls drop after 8 cycles, mc_timeout=1 and stays 1; rst_n pulse mid-MC_WAIT clears all outputs immediately.
- HAZARD_PERF_CNT_EN defined: 2 load-use hazards plus 1 branch -> perf_stall_cnt=2, perf_flush_cnt=1.
